// File: rtl/reg_write_sched_if.sv
// reg_write_sched_if: requester, register-port and status signals of the write scheduler
interface reg_write_sched_if #(
    parameter int DATA_WIDTH = 16
);
    logic                  init_req;
    logic                  a_valid;
    logic [7:0]            a_addr;
    logic [DATA_WIDTH-1:0] a_data;
    logic                  a_ready;
    logic                  m_valid;
    logic [7:0]            m_addr;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  m_ready;
    logic                  wr_en;
    logic [7:0]            wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  init_done;
    logic                  err_oob;
    modport master (
        output init_req, a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        input  a_ready, m_ready, wr_en, wr_addr, wr_data, init_done, err_oob
    );
    modport slave (
        input  init_req, a_valid, a_addr, a_data, m_valid, m_addr, m_data,
        output a_ready, m_ready, wr_en, wr_addr, wr_data, init_done, err_oob
    );
endinterface

// File: rtl/reg_write_sched.sv
// reg_write_sched: round-robin ALU/load arbiter for the register write port with a clear pass after reset/init_req
module reg_write_sched #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 16,
    parameter int RAM_DEPTH  = 1 << ADDR_WIDTH
) (
    input  logic            clk,
    input  logic            rst,
    reg_write_sched_if.slave bus
);
    typedef enum logic {INIT, RUN} state_t;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(RAM_DEPTH - 1);
    localparam logic [8:0] DEPTH9 = 9'(RAM_DEPTH);
    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
    logic                  prio_q, prio_d;
    logic                  wr_en_q, wr_en_d;
    logic [7:0]            wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  err_q, err_d;
    logic                  gnt_a, gnt_m, both;
    logic [7:0]            sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    // prio_q=1 means M wins the next contended cycle
    assign both     = bus.a_valid && bus.m_valid;
    assign gnt_a    = state_q == RUN && !bus.init_req && bus.a_valid && (!bus.m_valid || !prio_q);
    assign gnt_m    = state_q == RUN && !bus.init_req && bus.m_valid && !gnt_a;
    assign sel_addr = gnt_a ? bus.a_addr : bus.m_addr;
    assign sel_data = gnt_a ? bus.a_data : bus.m_data;
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        prio_d    = prio_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        err_d     = err_q;
        if (state_q == INIT) begin
            wr_en_d   = 1'b1;
            wr_addr_d = 8'(cnt_q);
            wr_data_d = '0;
            cnt_d     = cnt_q == LAST ? '0 : cnt_q + 1'b1;
            state_d   = cnt_q == LAST ? RUN : INIT;
        end else if (bus.init_req) begin
            state_d = INIT;
            cnt_d   = '0;
        end else if (gnt_a || gnt_m) begin
            prio_d = both ? ~prio_q : prio_q;
            if ({1'b0, sel_addr} < DEPTH9) begin
                wr_en_d   = 1'b1;
                wr_addr_d = sel_addr;
                wr_data_d = sel_data;
            end else begin
                err_d = 1'b1;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT;
            cnt_q     <= '0;
            prio_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            prio_q    <= prio_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            err_q     <= err_d;
        end
    end
    assign bus.a_ready   = gnt_a;
    assign bus.m_ready   = gnt_m;
    assign bus.wr_en     = wr_en_q;
    assign bus.wr_addr   = wr_addr_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.init_done = state_q == RUN;
    assign bus.err_oob   = err_q;
endmodule

// File: tb/tb_reg_write_sched.sv
// tb_reg_write_sched: directed + random check of reg_write_sched against a behavioural scheduler model
module tb_reg_write_sched;
    localparam int DEPTH = 32;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_chk = 0;
    int n_fail = 0;
    reg_write_sched_if bus ();
    reg_write_sched dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    bit        armed = 0;
    bit        running;
    int        pos;
    bit        prio_m;
    bit        e_wen;
    logic [7:0]  e_waddr;
    logic [15:0] e_wdata;
    bit        e_err;
    logic [15:0] exp_regs [DEPTH];
    logic [15:0] dut_regs [DEPTH];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // 0 = nobody, 1 = A, 2 = M
    function automatic int winner();
        if (!running || bus.init_req) return 0;
        if (bus.a_valid && bus.m_valid) return prio_m ? 2 : 1;
        return bus.a_valid ? 1 : (bus.m_valid ? 2 : 0);
    endfunction
    always @(posedge clk) begin
        int g;
        logic [7:0] ad;
        g = winner();
        if (rst) begin
            armed <= 1; running <= 0; pos <= 0; prio_m <= 0;
            e_wen <= 0; e_waddr <= 0; e_wdata <= 0; e_err <= 0;
        end else if (!running) begin
            e_wen <= 1; e_waddr <= 8'(pos); e_wdata <= 0;
            running <= pos == DEPTH - 1;
            pos <= pos == DEPTH - 1 ? 0 : pos + 1;
        end else begin
            e_wen <= 0;
            if (bus.init_req) begin
                running <= 0;
                pos <= 0;
            end else if (g != 0) begin
                ad = g == 1 ? bus.a_addr : bus.m_addr;
                if (bus.a_valid && bus.m_valid) prio_m <= !prio_m;
                if (int'(ad) < DEPTH) begin
                    e_wen <= 1; e_waddr <= ad;
                    e_wdata <= g == 1 ? bus.a_data : bus.m_data;
                end else e_err <= 1;
            end
        end
    end
    always @(negedge clk) begin
        if (e_wen) exp_regs[e_waddr[4:0]] <= e_wdata;
        if (bus.wr_en === 1'b1 && bus.wr_addr < 8'(DEPTH)) dut_regs[bus.wr_addr[4:0]] <= bus.wr_data;
    end
    always @(negedge clk) begin
        if (armed) begin
            chk("wr_en", 32'(bus.wr_en), 32'(e_wen));
            chk("wr_addr", 32'(bus.wr_addr), 32'(e_waddr));
            chk("wr_data", 32'(bus.wr_data), 32'(e_wdata));
            chk("init_done", 32'(bus.init_done), 32'(running));
            chk("err_oob", 32'(bus.err_oob), 32'(e_err));
            chk("a_ready", 32'(bus.a_ready), 32'(winner() == 1));
            chk("m_ready", 32'(bus.m_ready), 32'(winner() == 2));
        end
    end
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic idle();
        bus.init_req = 0; bus.a_valid = 0; bus.m_valid = 0;
    endtask
    task automatic check_regs(input string name);
        int bad = 0;
        @(negedge clk);
        #1;
        for (int i = 0; i < DEPTH; i++) if (dut_regs[i] !== exp_regs[i]) bad++;
        chk(name, 32'(bad), 32'd0);
    endtask
    initial begin
        int bad;
        idle();
        bus.a_addr = 0; bus.a_data = 0; bus.m_addr = 0; bus.m_data = 0;
        step();
        rst = 0;
        for (int k = 1; k <= 32; k++) begin
            step();
            if (k == 1) begin
                chk("t1_first_en", 32'(bus.wr_en), 32'd1);
                chk("t1_first_addr", 32'(bus.wr_addr), 32'd0);
            end
            if (k == 31) chk("t1_done_low", 32'(bus.init_done), 32'd0);
            if (k == 32) begin
                chk("t1_done_high", 32'(bus.init_done), 32'd1);
                chk("t1_last_addr", 32'(bus.wr_addr), 32'd31);
            end
        end
        @(negedge clk);
        #1;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) if (dut_regs[i] !== 16'h0) bad++;
        chk("t1_all_zero", 32'(bad), 32'd0);
        step();
        bus.a_valid = 1; bus.a_addr = 8'd3; bus.a_data = 16'hBEEF;
        #1;
        chk("t2_a_ready", 32'(bus.a_ready), 32'd1);
        step();
        idle();
        chk("t2_wr_en", 32'(bus.wr_en), 32'd1);
        chk("t2_wr_addr", 32'(bus.wr_addr), 32'd3);
        @(negedge clk);
        #1;
        chk("t2_reg3", 32'(dut_regs[3]), 32'hBEEF);
        step();
        for (int i = 0; i < 4; i++) begin
            bus.a_valid = 1; bus.a_addr = 8'd1; bus.a_data = 16'(16'h1000 + i);
            bus.m_valid = 1; bus.m_addr = 8'd2; bus.m_data = 16'(16'h2000 + i);
            #1;
            chk("t3_a_ready", 32'(bus.a_ready), 32'(i % 2 == 0));
            chk("t3_m_ready", 32'(bus.m_ready), 32'(i % 2 == 1));
            step();
        end
        idle();
        @(negedge clk);
        #1;
        chk("t3_reg1", 32'(dut_regs[1]), 32'h1002);
        chk("t3_reg2", 32'(dut_regs[2]), 32'h2003);
        step();
        bus.m_valid = 1; bus.m_addr = 8'd40; bus.m_data = 16'h5555;
        #1;
        chk("t4_m_ready", 32'(bus.m_ready), 32'd1);
        step();
        idle();
        chk("t4_wr_en_low", 32'(bus.wr_en), 32'd0);
        chk("t4_err", 32'(bus.err_oob), 32'd1);
        bus.a_valid = 1; bus.a_addr = 8'd5; bus.a_data = 16'h1234;
        step();
        idle();
        chk("t4_good_en", 32'(bus.wr_en), 32'd1);
        step();
        chk("t4_err_sticky", 32'(bus.err_oob), 32'd1);
        rst = 1;
        step();
        rst = 0;
        repeat (17) step();
        chk("t5_mid_addr", 32'(bus.wr_addr), 32'd16);
        rst = 1;
        step();
        rst = 0;
        chk("t5_rst_en", 32'(bus.wr_en), 32'd0);
        step();
        chk("t5_restart_addr", 32'(bus.wr_addr), 32'd0);
        repeat (4) step();
        bus.init_req = 1;
        step();
        bus.init_req = 0;
        repeat (25) step();
        chk("t5_done_low", 32'(bus.init_done), 32'd0);
        step();
        chk("t5_done_high", 32'(bus.init_done), 32'd1);
        chk("t5_last_addr", 32'(bus.wr_addr), 32'd31);
        bus.init_req = 1;
        bus.a_valid = 1; bus.a_addr = 8'd7; bus.a_data = 16'hA7A7;
        bus.m_valid = 1; bus.m_addr = 8'd8; bus.m_data = 16'hB8B8;
        #1;
        chk("t6_a_ready_init", 32'(bus.a_ready), 32'd0);
        chk("t6_m_ready_init", 32'(bus.m_ready), 32'd0);
        step();
        bus.init_req = 0;
        repeat (32) step();
        chk("t6_done", 32'(bus.init_done), 32'd1);
        chk("t6_a_first", 32'(bus.a_ready), 32'd1);
        chk("t6_m_first", 32'(bus.m_ready), 32'd0);
        step();
        idle();
        chk("t6_wr_addr", 32'(bus.wr_addr), 32'd7);
        for (int c = 0; c < 3000; c++) begin
            rst = $urandom_range(0, 399) == 0;
            bus.init_req = $urandom_range(0, 59) == 0;
            bus.a_valid = 1'($urandom);
            bus.m_valid = 1'($urandom);
            bus.a_addr = $urandom_range(0, 7) == 0 ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            bus.m_addr = $urandom_range(0, 7) == 0 ? 8'($urandom_range(32, 255)) : 8'($urandom_range(0, 31));
            bus.a_data = 16'($urandom);
            bus.m_data = 16'($urandom);
            step();
        end
        rst = 0;
        idle();
        repeat (40) step();
        check_regs("rand_regs");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
